// File: rtl/mem_access_ctrl_if.sv
// Request/response and memory-port signal bundle for mem_access_ctrl.
// The slave modport is the controller's view; master is the datapath/memory side.
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
) ();
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] req_dst;
    logic [DATA_W-1:0] req_data;
    logic [ADDR_W-1:0] req_len;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              done;
    logic              busy;

    logic [ADDR_W-1:0] M_add;
    logic [DATA_W-1:0] M_wd;
    logic              M_we;
    logic              M_re;
    logic [DATA_W-1:0] M_rd;

    modport slave (
        input  req_valid, req_op, req_addr, req_dst, req_data, req_len, M_rd,
        output req_ready, rsp_valid, rsp_data, done, busy,
        output M_add, M_wd, M_we, M_re
    );

    modport master (
        output req_valid, req_op, req_addr, req_dst, req_data, req_len, M_rd,
        input  req_ready, rsp_valid, rsp_data, done, busy,
        input  M_add, M_wd, M_we, M_re
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Sequences single/multi-word accesses onto the data-memory port; read data 2 cycles after accept, copy 2 cycles/word, fill 1 cycle/word.
// Backpressure: req_ready only in IDLE; requests offered while busy are dropped, not queued.
module mem_access_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    mem_access_ctrl_if.slave   bus
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_COPY  = 2'b10;
    localparam logic [1:0] OP_FILL  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WRITE = 3'd2,
        S_CP_RD = 3'd3,
        S_CP_WR = 3'd4,
        S_FILL  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              done_q, done_d;

    logic              accept;
    logic              last_word;

    assign accept    = bus.req_valid && (state_q == S_IDLE);
    assign last_word = (idx_q == len_q);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (bus.req_op)
                        OP_READ:  state_d = S_READ;
                        OP_WRITE: state_d = S_WRITE;
                        OP_COPY:  state_d = S_CP_RD;
                        OP_FILL:  state_d = S_FILL;
                        default:  state_d = S_IDLE;
                    endcase
                end
            end
            S_READ:  state_d = S_IDLE;
            S_WRITE: state_d = S_IDLE;
            S_CP_RD: state_d = S_CP_WR;
            S_CP_WR: state_d = last_word ? S_IDLE : S_CP_RD;
            S_FILL:  state_d = last_word ? S_IDLE : S_FILL;
            default: state_d = S_IDLE;
        endcase
    end

    // Request latch, word index, copy buffer and response registers
    always_comb begin
        addr_d     = addr_q;
        dst_d      = dst_q;
        data_d     = data_q;
        len_d      = len_q;
        idx_d      = idx_q;
        buf_d      = buf_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d = bus.req_addr;
                    dst_d  = bus.req_dst;
                    data_d = bus.req_data;
                    len_d  = bus.req_len;
                    idx_d  = '0;
                end
            end
            S_READ:  rsp_data_d = bus.M_rd;
            S_CP_RD: buf_d      = bus.M_rd;
            S_CP_WR: if (!last_word) idx_d = idx_q + 1'b1;
            S_FILL:  if (!last_word) idx_d = idx_q + 1'b1;
            default: ;
        endcase
        rsp_valid_d = (state_q == S_READ);
        done_d      = (state_q == S_READ) || (state_q == S_WRITE) ||
                      (((state_q == S_CP_WR) || (state_q == S_FILL)) && last_word);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q      <= '0;
            dst_q       <= '0;
            data_q      <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            buf_q       <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            dst_q       <= dst_d;
            data_q      <= data_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            buf_q       <= buf_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            done_q      <= done_d;
        end
    end

    // Memory port decoded from registered state only; reset forces IDLE so enables drop asynchronously.
    always_comb begin
        bus.M_add = '0;
        bus.M_wd  = '0;
        bus.M_we  = 1'b0;
        bus.M_re  = 1'b0;
        case (state_q)
            S_READ: begin
                bus.M_re  = 1'b1;
                bus.M_add = addr_q;
            end
            S_WRITE: begin
                bus.M_we  = 1'b1;
                bus.M_add = addr_q;
                bus.M_wd  = data_q;
            end
            S_CP_RD: begin
                bus.M_re  = 1'b1;
                bus.M_add = addr_q + idx_q;
            end
            S_CP_WR: begin
                bus.M_we  = 1'b1;
                bus.M_add = dst_q + idx_q;
                bus.M_wd  = buf_q;
            end
            S_FILL: begin
                bus.M_we  = 1'b1;
                bus.M_add = addr_q + idx_q;
                bus.M_wd  = data_q;
            end
            default: ;
        endcase
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.done      = done_q;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Initiator side of the 16x4 data-memory port. Accepts single-word read/write and multi-word copy/fill requests from the datapath through a valid/ready handshake. Sequences the memory control signals M_add, M_wd, M_we and M_re, captures M_rd, and returns read data plus a completion pulse. Sits between the control unit/datapath and the data memory; it is the only driver of the memory port.

Parameters:
ADDR_W, 4, memory address width (16 words); all address arithmetic is modulo 2**ADDR_W
DATA_W, 4, memory word width

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_op  in  2  00 read, 01 write, 10 copy, 11 fill
req_addr  in  ADDR_W  read/write address; copy source; fill start address
req_dst  in  ADDR_W  copy destination start; ignored otherwise
req_data  in  DATA_W  write/fill value
req_len  in  ADDR_W  copy/fill word count minus 1 (0..15 gives 1..16 words); ignored for read/write
rsp_valid  out  1  one-cycle pulse; rsp_data valid (read only)
rsp_data  out  DATA_W  read result, held until next read response
done  out  1  one-cycle pulse when any operation completes
busy  out  1  high whenever state is not IDLE
M_add  out  ADDR_W  memory address
M_wd  out  DATA_W  memory write data
M_we  out  1  memory write enable (write lands on the posedge where high)
M_re  out  1  memory read enable (M_rd combinational)
M_rd  in  DATA_W  memory read data

Behaviour:
- Reset (async, reset_n=0): state IDLE; req_ready=1 once released; rsp_valid, done, busy, M_we, M_re = 0; M_add, M_wd, rsp_data, index, buffer = 0.
- States: IDLE, READ, WRITE, CP_RD, CP_WR, FILL.
- IDLE: req_ready=1 (combinational from state); M_we=M_re=0, M_add=M_wd=0. Handshake at posedge when req_valid&&req_ready: latch op, addr, dst, data, len; clear index i; go to READ/WRITE/CP_RD/FILL.
- req_ready=0 outside IDLE; req_valid there is ignored, not queued.
- READ (1 cycle): M_re=1, M_add=addr. At the closing edge, rsp_data<=M_rd; rsp_valid=1 and done=1 for the next cycle (IDLE). Latency: accept at edge k, rsp_valid high in cycle k+2.
- WRITE (1 cycle): M_we=1, M_add=addr, M_wd=data; next state IDLE with done=1.
- CP_RD: M_re=1, M_add=addr+i; buffer<=M_rd at the edge; next state CP_WR.
- CP_WR: M_we=1, M_add=dst+i, M_wd=buffer. If i==len, go to IDLE with done=1; else i<=i+1 and go to CP_RD.
- Copy is strictly ascending, word-interleaved, 2 cycles per word. Overlapping ranges are defined by this ordering: dst=src+1 replicates mem[src].
- FILL: M_we=1, M_add=addr+i, M_wd=data each cycle. If i==len, go to IDLE with done=1; else i<=i+1. 1 cycle per word.
- Address sums wrap modulo 16 (14+3 gives 1). req_len=15 covers the whole memory.
- M_we and M_re are never high in the same cycle. Memory outputs are decoded from registered state only, so they are glitch-free with respect to request inputs.
- A new request may be accepted in the same cycle that done is high.
- Reset mid-operation: immediate abort. M_we/M_re drop asynchronously and no done is issued. Words whose write edge already occurred stay written; no others are written.

Test Plan:
- Memory preloaded mem[i]=i; read addr 9 -> M_re high exactly one cycle with M_add=9; rsp_valid=done=1 at cycle k+2; rsp_data=9.
- Write addr 3 data 0xA, then read addr 3 -> done after 1 busy cycle; second response rsp_data=0xA; req_valid during busy ignored.
- Copy src 2, dst 8, len 3 -> 8 busy cycles, alternating M_re/M_we; mem[8..11]=2,3,4,5; single done pulse; mem[2..5] unchanged.
- Fill addr 14, len 3, data 5 -> M_add sequence 14,15,0,1; those words =5; mem[2..13] unchanged; done after 4 busy cycles.
- Overlap copy src 0, dst 1, len 2 -> mem[1..3]=0,0,0.
- Copy src 0, dst 8, len 7; assert reset_n=0 during cycle 4 -> M_we/M_re=0 immediately; mem[8]=0, mem[9]=1 written, mem[10..15] untouched; no done; req_ready=1 after release.
